mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multicycle MIPS control FSM: the producing end of the ALU control interface.
- Decodes the latched instruction's Op/Funct and sequences fetch/decode/execute/memory/writeback.
- Each cycle it drives ALUOp, operand selects and all datapath write enables, and consumes the ALU Zero flag for branches.
- Sits beside the ALU, register file, IR/MDR/A/B/ALUOut registers and the unified memory port in the multicycle CPU.

Parameters:
- ALUOP_W, 4, width of ALUOp bus.
- Encoding (fixed): NOP 0, ADD 1, SUB 2, AND 3, OR 4, SLT 5, SLTU 6, NOR 7, XOR 8, SRLV 9, SLLV 10, SRAV 11.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- Op  in  6  IR[31:26], stable after IR write
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag (combinational, same cycle)
- mem_ready  in  1  memory completes the access this cycle
- ALUOp  out  4  ALU operation
- alu_srca  out  1  0=PC, 1=A
- alu_srcb  out  2  00=B, 01=const 4, 10=ext imm, 11=ext imm<<2
- op_swap  out  1  datapath swaps ALU A/B (variable shifts)
- ext_op  out  1  1=sign-extend, 0=zero-extend
- pc_src  out  2  00=ALU C, 01=ALUOut, 10=jump target {PC[31:28],IR[25:0],2'b0}
- pc_wr, ir_wr, mem_rd, mem_wr, iord, rf_wr  out  1 each  write/strobe enables (iord 0=PC, 1=ALUOut)
- reg_dst  out  2  00=rt, 01=rd, 10=$31
- wd_sel  out  2  00=ALUOut, 01=MDR, 10=PC
- illegal  out  1  one-cycle pulse in DECODE on unsupported instruction

Behaviour:
- Reset: state=FETCH; while rst=1 all outputs 0 (ALUOp=NOP). Reset mid-instruction aborts it; no partial writes after rst rises.
- Outputs are Moore per state, except: pc_wr/ir_wr in FETCH gated by mem_ready; pc_wr in BRANCH gated by Zero. Unlisted outputs are 0.
- FETCH: mem_rd=1, iord=0, srca=0, srcb=01, ALUOp=ADD, pc_src=00. When mem_ready=1: pc_wr=ir_wr=1 and go to DECODE; otherwise hold state.
- DECODE: srca=0, srcb=11, ext_op=1, ALUOp=ADD (branch target into ALUOut).
  - Next state: R -> REXEC; lw/sw -> MEMADR; beq/bne -> BRANCH; j -> JUMP; jal -> JAL; addi/slti/andi/ori/xori -> IEXEC.
  - Unknown Op, or R with unknown Funct: illegal=1, go to FETCH.
- Opcodes: R 000000, j 000010, jal 000011, beq 000100, bne 000101, addi 001000, slti 001010, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011.
- Funct map:
  - 100000/100001 -> ADD; 100010/100011 -> SUB
  - 100100 -> AND; 100101 -> OR; 100110 -> XOR; 100111 -> NOR
  - 101010 -> SLT; 101011 -> SLTU
  - 000100 -> SLLV; 000110 -> SRLV; 000111 -> SRAV; these three also assert op_swap=1 (A=rt, B=rs).
- REXEC: srca=1, srcb=00, ALUOp per Funct -> ALUWB.
- IEXEC: srca=1, srcb=10.
  - addi: ADD, ext_op=1. slti: SLT, ext_op=1.
  - andi: AND, ext_op=0. ori: OR, ext_op=0. xori: XOR, ext_op=0.
  - Next state: ALUWB.
- ALUWB: rf_wr=1, wd_sel=00, reg_dst=01 if Op==0 else 00 -> FETCH.
- MEMADR: srca=1, srcb=10, ext_op=1, ADD. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_rd=1, iord=1; holds until mem_ready, then MEMWB.
- MEMWB: rf_wr=1, wd_sel=01, reg_dst=00 -> FETCH.
- MEMWR: mem_wr=1, iord=1; holds until mem_ready, then FETCH.
- BRANCH: srca=1, srcb=00, ALUOp=SUB, pc_src=01. pc_wr = Zero for beq, ~Zero for bne. -> FETCH.
- JUMP: pc_src=10, pc_wr=1 -> FETCH.
- JAL: pc_src=10, pc_wr=1, rf_wr=1, reg_dst=10, wd_sel=10. PC register still holds PC+4 this cycle. -> FETCH.
- Latency with mem_ready=1 in every memory state (cycles):
  - R-type, I-type ALU, sw: 4
  - lw: 5
  - beq/bne, j, jal: 3
- Each mem_ready=0 cycle adds one. mem_ready is ignored outside FETCH/MEMRD/MEMWR.
- Simultaneous rst and mem_ready: rst wins.
- Exactly one of pc_wr/rf_wr/mem_wr sources per state as listed; never mem_rd and mem_wr together.

Test Plan:
- rst=1 for 2 cycles, then release with mem_ready=1, Op=0, Funct=100010 -> all outputs 0 during reset; states F,D,REXEC(ALUOp=2),ALUWB(rf_wr=1, reg_dst=01); 4 cycles.
- Op=100011 (lw), mem_ready low for 2 cycles in MEMRD -> mem_rd=1, iord=1 held 3 cycles; then MEMWB wd_sel=01, rf_wr=1; total 7 cycles.
- Op=000100 (beq) with Zero=1, then with Zero=0; repeat for bne -> BRANCH pc_wr=1,0 for beq and 0,1 for bne; ALUOp=2, pc_src=01.
- Op=000011 (jal) -> JAL: pc_wr=1, rf_wr=1, reg_dst=10, wd_sel=10, pc_src=10; 3 cycles. Op=001100 (andi) -> ext_op=0, ALUOp=3.
- Funct=000111 (srav) -> ALUOp=11, op_swap=1. Op=111111 -> illegal pulses 1 cycle in DECODE; no rf_wr/mem_wr; back to FETCH.
- rst asserted asynchronously mid-MEMWR (between edges) -> mem_wr drops to 0 immediately; after release, FETCH.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// master = controller (drives ALU/mux/enable controls), slave = datapath.
interface mc_ctrl_if #(parameter int ALUOP_W = 4);
  logic [5:0]         Op;
  logic [5:0]         Funct;
  logic               Zero;
  logic               mem_ready;
  logic [ALUOP_W-1:0] ALUOp;
  logic               alu_srca;
  logic [1:0]         alu_srcb;
  logic               op_swap;
  logic               ext_op;
  logic [1:0]         pc_src;
  logic               pc_wr;
  logic               ir_wr;
  logic               mem_rd;
  logic               mem_wr;
  logic               iord;
  logic               rf_wr;
  logic [1:0]         reg_dst;
  logic [1:0]         wd_sel;
  logic               illegal;

  modport master (
    input  Op, Funct, Zero, mem_ready,
    output ALUOp, alu_srca, alu_srcb, op_swap, ext_op, pc_src, pc_wr, ir_wr,
           mem_rd, mem_wr, iord, rf_wr, reg_dst, wd_sel, illegal
  );

  modport slave (
    output Op, Funct, Zero, mem_ready,
    input  ALUOp, alu_srca, alu_srcb, op_swap, ext_op, pc_src, pc_wr, ir_wr,
           mem_rd, mem_wr, iord, rf_wr, reg_dst, wd_sel, illegal
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback.
// Moore outputs per state; FETCH enables gated by mem_ready, BRANCH pc_wr by Zero.
module mc_ctrl #(
  parameter int ALUOP_W = 4
) (
  input logic      clk,
  input logic      rst,
  mc_ctrl_if.master bus
);

  localparam logic [ALUOP_W-1:0] A_NOP  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] A_ADD  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] A_SUB  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] A_AND  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] A_OR   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] A_SLT  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] A_SLTU = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] A_NOR  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] A_XOR  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] A_SRLV = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] A_SLLV = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] A_SRAV = ALUOP_W'(11);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_REXEC, S_IEXEC, S_ALUWB, S_MEMADR,
    S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_JAL
  } state_t;

  state_t state;

  logic               r_ok;
  logic [ALUOP_W-1:0] r_alu;
  logic               r_swap;
  logic [ALUOP_W-1:0] i_alu;
  logic               i_ext;
  logic               op_ok;

  always_comb begin
    r_ok   = 1'b1;
    r_alu  = A_NOP;
    r_swap = 1'b0;
    case (bus.Funct)
      6'b100000, 6'b100001: r_alu = A_ADD;
      6'b100010, 6'b100011: r_alu = A_SUB;
      6'b100100:            r_alu = A_AND;
      6'b100101:            r_alu = A_OR;
      6'b100110:            r_alu = A_XOR;
      6'b100111:            r_alu = A_NOR;
      6'b101010:            r_alu = A_SLT;
      6'b101011:            r_alu = A_SLTU;
      // variable shifts take the shift amount from rs, so operands are swapped
      6'b000100: begin r_alu = A_SLLV; r_swap = 1'b1; end
      6'b000110: begin r_alu = A_SRLV; r_swap = 1'b1; end
      6'b000111: begin r_alu = A_SRAV; r_swap = 1'b1; end
      default:              r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    i_alu = A_ADD;
    i_ext = 1'b1;
    case (bus.Op)
      OP_SLTI: i_alu = A_SLT;
      OP_ANDI: begin i_alu = A_AND; i_ext = 1'b0; end
      OP_ORI:  begin i_alu = A_OR;  i_ext = 1'b0; end
      OP_XORI: begin i_alu = A_XOR; i_ext = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    case (bus.Op)
      OP_R:                                         op_ok = r_ok;
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW,
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI:   op_ok = 1'b1;
      default:                                      op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          if (!op_ok) state <= S_FETCH;
          else case (bus.Op)
            OP_R:          state <= S_REXEC;
            OP_LW, OP_SW:  state <= S_MEMADR;
            OP_BEQ, OP_BNE: state <= S_BRANCH;
            OP_J:          state <= S_JUMP;
            OP_JAL:        state <= S_JAL;
            default:       state <= S_IEXEC;
          endcase
        end
        S_REXEC:  state <= S_ALUWB;
        S_IEXEC:  state <= S_ALUWB;
        S_MEMADR: state <= (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (bus.mem_ready) state <= S_MEMWB;
        S_MEMWR:  if (bus.mem_ready) state <= S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Forced to zero while rst is high so an async reset kills any in-flight write at once.
  always_comb begin
    bus.ALUOp    = A_NOP;
    bus.alu_srca = 1'b0;
    bus.alu_srcb = 2'b00;
    bus.op_swap  = 1'b0;
    bus.ext_op   = 1'b0;
    bus.pc_src   = 2'b00;
    bus.pc_wr    = 1'b0;
    bus.ir_wr    = 1'b0;
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.iord     = 1'b0;
    bus.rf_wr    = 1'b0;
    bus.reg_dst  = 2'b00;
    bus.wd_sel   = 2'b00;
    bus.illegal  = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          bus.mem_rd   = 1'b1;
          bus.alu_srcb = 2'b01;
          bus.ALUOp    = A_ADD;
          bus.pc_wr    = bus.mem_ready;
          bus.ir_wr    = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_srcb = 2'b11;
          bus.ext_op   = 1'b1;
          bus.ALUOp    = A_ADD;
          bus.illegal  = !op_ok;
        end
        S_REXEC: begin
          bus.alu_srca = 1'b1;
          bus.ALUOp    = r_alu;
          bus.op_swap  = r_swap;
        end
        S_IEXEC: begin
          bus.alu_srca = 1'b1;
          bus.alu_srcb = 2'b10;
          bus.ALUOp    = i_alu;
          bus.ext_op   = i_ext;
        end
        S_ALUWB: begin
          bus.rf_wr   = 1'b1;
          bus.reg_dst = (bus.Op == OP_R) ? 2'b01 : 2'b00;
        end
        S_MEMADR: begin
          bus.alu_srca = 1'b1;
          bus.alu_srcb = 2'b10;
          bus.ext_op   = 1'b1;
          bus.ALUOp    = A_ADD;
        end
        S_MEMRD: begin
          bus.mem_rd = 1'b1;
          bus.iord   = 1'b1;
        end
        S_MEMWB: begin
          bus.rf_wr  = 1'b1;
          bus.wd_sel = 2'b01;
        end
        S_MEMWR: begin
          bus.mem_wr = 1'b1;
          bus.iord   = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_srca = 1'b1;
          bus.ALUOp    = A_SUB;
          bus.pc_src   = 2'b01;
          bus.pc_wr    = (bus.Op == OP_BNE) ? !bus.Zero : bus.Zero;
        end
        S_JUMP: begin
          bus.pc_src = 2'b10;
          bus.pc_wr  = 1'b1;
        end
        S_JAL: begin
          bus.pc_src  = 2'b10;
          bus.pc_wr   = 1'b1;
          bus.rf_wr   = 1'b1;
          bus.reg_dst = 2'b10;
          bus.wd_sel  = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed cycle-by-cycle vectors for mc_ctrl; each vector checks all outputs once.
module tb_mc_ctrl;

  typedef struct packed {
    logic [3:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       swap;
    logic       ext;
    logic [1:0] pcsrc;
    logic       pcwr;
    logic       irwr;
    logic       mrd;
    logic       mwr;
    logic       iord;
    logic       rfwr;
    logic [1:0] regdst;
    logic [1:0] wdsel;
    logic       ill;
  } out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       zero;
    logic       mr;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vq[$];

  mc_ctrl_if #(.ALUOP_W(4)) bus ();

  mc_ctrl #(.ALUOP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic out_t ex(input logic [3:0] a, input logic sa, input logic [1:0] sb,
                              input logic sw, input logic eo, input logic [1:0] ps,
                              input logic pw, input logic iw, input logic mrd, input logic mwr,
                              input logic io, input logic rw, input logic [1:0] rd,
                              input logic [1:0] ws, input logic il);
    out_t o;
    o = '{a, sa, sb, sw, eo, ps, pw, iw, mrd, mwr, io, rw, rd, ws, il};
    return o;
  endfunction

  function automatic out_t x_fetch(input logic mr);
    return ex(4'd1, 0, 2'b01, 0, 0, 2'b00, mr, mr, 1, 0, 0, 0, 2'b00, 2'b00, 0);
  endfunction
  function automatic out_t x_dec(input logic il);
    return ex(4'd1, 0, 2'b11, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, il);
  endfunction
  function automatic out_t x_rexec(input logic [3:0] a, input logic sw);
    return ex(a, 1, 2'b00, sw, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
  endfunction
  function automatic out_t x_iexec(input logic [3:0] a, input logic eo);
    return ex(a, 1, 2'b10, 0, eo, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
  endfunction
  function automatic out_t x_aluwb(input logic [1:0] rd);
    return ex(4'd0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, rd, 2'b00, 0);
  endfunction
  function automatic out_t x_memadr();
    return ex(4'd1, 1, 2'b10, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
  endfunction
  function automatic out_t x_memrd();
    return ex(4'd0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0);
  endfunction
  function automatic out_t x_memwb();
    return ex(4'd0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0);
  endfunction
  function automatic out_t x_memwr();
    return ex(4'd0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0);
  endfunction
  function automatic out_t x_branch(input logic pw);
    return ex(4'd2, 1, 2'b00, 0, 0, 2'b01, pw, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
  endfunction
  function automatic out_t x_jump();
    return ex(4'd0, 0, 2'b00, 0, 0, 2'b10, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
  endfunction
  function automatic out_t x_jal();
    return ex(4'd0, 0, 2'b00, 0, 0, 2'b10, 1, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0);
  endfunction

  task automatic add(input string nm, input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic mr, input out_t e);
    vec_t v;
    v.name = nm; v.rst = r; v.op = op; v.fn = fn; v.zero = z; v.mr = mr; v.exp = e;
    vq.push_back(v);
  endtask

  function automatic out_t sample();
    out_t o;
    o = {bus.ALUOp, bus.alu_srca, bus.alu_srcb, bus.op_swap, bus.ext_op, bus.pc_src,
         bus.pc_wr, bus.ir_wr, bus.mem_rd, bus.mem_wr, bus.iord, bus.rf_wr,
         bus.reg_dst, bus.wd_sel, bus.illegal};
    return o;
  endfunction

  task automatic check(input string nm, input out_t e);
    out_t a;
    a = sample();
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // Inputs change at the falling edge; outputs are checked 1ns later, well before the rising edge.
  task automatic step(input vec_t v);
    @(negedge clk);
    rst = v.rst; bus.Op = v.op; bus.Funct = v.fn; bus.Zero = v.zero; bus.mem_ready = v.mr;
    #1;
    check(v.name, v.exp);
  endtask

  initial begin
    out_t z0;
    vec_t v;
    z0 = '0;
    bus.Op = 6'd0; bus.Funct = 6'd0; bus.Zero = 1'b0; bus.mem_ready = 1'b0;
    #1 rst = 1'b1;

    add("rst0", 1, 6'b000000, 6'b100010, 0, 1, z0);
    add("rst1", 1, 6'b000000, 6'b100010, 0, 1, z0);
    add("sub_f", 0, 6'b000000, 6'b100010, 0, 1, x_fetch(1));
    add("sub_d", 0, 6'b000000, 6'b100010, 0, 1, x_dec(0));
    add("sub_x", 0, 6'b000000, 6'b100010, 0, 1, x_rexec(4'd2, 0));
    add("sub_wb", 0, 6'b000000, 6'b100010, 0, 1, x_aluwb(2'b01));
    add("lw_f", 0, 6'b100011, 6'b000000, 0, 1, x_fetch(1));
    add("lw_d", 0, 6'b100011, 6'b000000, 0, 1, x_dec(0));
    add("lw_adr", 0, 6'b100011, 6'b000000, 0, 1, x_memadr());
    add("lw_rd0", 0, 6'b100011, 6'b000000, 0, 0, x_memrd());
    add("lw_rd1", 0, 6'b100011, 6'b000000, 0, 0, x_memrd());
    add("lw_rd2", 0, 6'b100011, 6'b000000, 0, 1, x_memrd());
    add("lw_wb", 0, 6'b100011, 6'b000000, 0, 1, x_memwb());
    add("beq1_f", 0, 6'b000100, 6'b000000, 1, 1, x_fetch(1));
    add("beq1_d", 0, 6'b000100, 6'b000000, 1, 1, x_dec(0));
    add("beq1_br", 0, 6'b000100, 6'b000000, 1, 1, x_branch(1));
    add("beq0_f", 0, 6'b000100, 6'b000000, 0, 1, x_fetch(1));
    add("beq0_d", 0, 6'b000100, 6'b000000, 0, 1, x_dec(0));
    add("beq0_br", 0, 6'b000100, 6'b000000, 0, 1, x_branch(0));
    add("bne1_f", 0, 6'b000101, 6'b000000, 1, 1, x_fetch(1));
    add("bne1_d", 0, 6'b000101, 6'b000000, 1, 1, x_dec(0));
    add("bne1_br", 0, 6'b000101, 6'b000000, 1, 1, x_branch(0));
    add("bne0_f", 0, 6'b000101, 6'b000000, 0, 1, x_fetch(1));
    add("bne0_d", 0, 6'b000101, 6'b000000, 0, 1, x_dec(0));
    add("bne0_br", 0, 6'b000101, 6'b000000, 0, 1, x_branch(1));
    add("jal_f", 0, 6'b000011, 6'b000000, 0, 1, x_fetch(1));
    add("jal_d", 0, 6'b000011, 6'b000000, 0, 1, x_dec(0));
    add("jal_x", 0, 6'b000011, 6'b000000, 0, 1, x_jal());
    add("andi_f", 0, 6'b001100, 6'b000000, 0, 1, x_fetch(1));
    add("andi_d", 0, 6'b001100, 6'b000000, 0, 1, x_dec(0));
    add("andi_x", 0, 6'b001100, 6'b000000, 0, 1, x_iexec(4'd3, 0));
    add("andi_wb", 0, 6'b001100, 6'b000000, 0, 1, x_aluwb(2'b00));
    add("slti_f", 0, 6'b001010, 6'b000000, 0, 1, x_fetch(1));
    add("slti_d", 0, 6'b001010, 6'b000000, 0, 1, x_dec(0));
    add("slti_x", 0, 6'b001010, 6'b000000, 0, 1, x_iexec(4'd5, 1));
    add("slti_wb", 0, 6'b001010, 6'b000000, 0, 1, x_aluwb(2'b00));
    add("srav_f", 0, 6'b000000, 6'b000111, 0, 1, x_fetch(1));
    add("srav_d", 0, 6'b000000, 6'b000111, 0, 1, x_dec(0));
    add("srav_x", 0, 6'b000000, 6'b000111, 0, 1, x_rexec(4'd11, 1));
    add("srav_wb", 0, 6'b000000, 6'b000111, 0, 1, x_aluwb(2'b01));
    add("ill_f", 0, 6'b111111, 6'b000000, 0, 1, x_fetch(1));
    add("ill_d", 0, 6'b111111, 6'b000000, 0, 1, x_dec(1));
    add("illr_f", 0, 6'b000000, 6'b000001, 0, 1, x_fetch(1));
    add("illr_d", 0, 6'b000000, 6'b000001, 0, 1, x_dec(1));
    add("j_stall", 0, 6'b000010, 6'b000000, 0, 0, x_fetch(0));
    add("j_f", 0, 6'b000010, 6'b000000, 0, 1, x_fetch(1));
    add("j_d", 0, 6'b000010, 6'b000000, 0, 1, x_dec(0));
    add("j_x", 0, 6'b000010, 6'b000000, 0, 1, x_jump());
    add("sw_f", 0, 6'b101011, 6'b000000, 0, 1, x_fetch(1));
    add("sw_d", 0, 6'b101011, 6'b000000, 0, 1, x_dec(0));
    add("sw_adr", 0, 6'b101011, 6'b000000, 0, 1, x_memadr());
    add("sw_wr", 0, 6'b101011, 6'b000000, 0, 1, x_memwr());
    add("xor_f", 0, 6'b000000, 6'b100110, 0, 1, x_fetch(1));
    add("xor_d", 0, 6'b000000, 6'b100110, 0, 1, x_dec(0));
    add("xor_x", 0, 6'b000000, 6'b100110, 0, 1, x_rexec(4'd8, 0));
    add("xor_wb", 0, 6'b000000, 6'b100110, 0, 1, x_aluwb(2'b01));
    // sw whose write is cut short by an asynchronous reset
    add("swr_f", 0, 6'b101011, 6'b000000, 0, 1, x_fetch(1));
    add("swr_d", 0, 6'b101011, 6'b000000, 0, 1, x_dec(0));
    add("swr_adr", 0, 6'b101011, 6'b000000, 0, 1, x_memadr());
    add("swr_wr", 0, 6'b101011, 6'b000000, 0, 0, x_memwr());

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      step(v);
    end

    #2 rst = 1'b1;
    #1 check("async_rst_memwr", z0);
    @(negedge clk);
    bus.mem_ready = 1'b1;
    #1 check("rst_wins_mr", z0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_fetch", x_fetch(1));
    @(negedge clk);
    #1 check("post_rst_dec", x_dec(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
